// File: rtl/mem_io_pkg.sv
// Shared definitions for the data-memory / MMIO bus arbiter:
// FSM state encoding, IO region base and the IO register map.
package mem_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Default IO region base; an access is IO when (addr & base) == base.
  localparam logic [31:0] IO_BASE_DEF  = 32'hFFFF_FC00;

  // IO register map
  localparam logic [31:0] IO_LED       = 32'hFFFF_FC60;
  localparam logic [31:0] IO_LED_ONE   = 32'hFFFF_FC68;
  localparam logic [31:0] IO_SWITCH    = 32'hFFFF_FC70;
  localparam logic [31:0] IO_TEST_IDX  = 32'hFFFF_FC78;
  localparam logic [31:0] IO_INPUT_CTL = 32'hFFFF_FC7C;
  localparam logic [31:0] IO_TUBE      = 32'hFFFF_FC80;

  // True when the byte address falls in the IO region described by base.
  function automatic logic addr_is_io(input logic [31:0] addr, input logic [31:0] base);
    return (addr & base) == base;
  endfunction

endpackage

// File: rtl/mem_io_arb_pick.sv
// Combinational winner select between two requesters.
// grant = 0 selects M0, grant = 1 selects M1.
// MEM_IO_ARB_RR_EN: when defined, a simultaneous request is resolved by the
// round-robin pointer; otherwise M0 has fixed priority and no pointer exists.
module mem_io_arb_pick (
  input  logic req0,
  input  logic req1,
`ifdef MEM_IO_ARB_RR_EN
  input  logic ptr,
`endif
  output logic grant
);

  // Winner select; value is don't-care when nobody requests.
  always_comb begin
`ifdef MEM_IO_ARB_RR_EN
    grant = (req0 && req1) ? ptr : req1;
`else
    grant = req1 && !req0;
`endif
  end

endmodule

// File: rtl/mem_io_bus_arbiter.sv
// Two-requester arbiter for the shared data-RAM / MMIO bus.
// Each grant runs one single-beat access: IDLE -> ISSUE -> [WAIT] -> RESP.
// Handshake: a requester raises req with we/addr/wdata and holds them until
// its one-cycle ack; rdata is valid only while ack=1. Requests are sampled
// only in IDLE, so a req dropped mid-transaction still gets its ack.
// MEM_IO_ARB_RR_EN selects round-robin arbitration (default: M0 priority).
module mem_io_bus_arbiter
  import mem_io_pkg::*;
#(
  parameter int          MEM_AW  = 14,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              io_rd,
  output logic              io_wr,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic [15:0]       io_rdata,
  output logic              busy,
  output state_t            fsm_state
);

  state_t      state_q;
  logic        win_q;   // 0 = M0, 1 = M1
  logic        we_q;
  logic        io_q;
  logic        grant;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_io;
  logic [31:0] issue_data;

`ifdef MEM_IO_ARB_RR_EN
  logic ptr_q;
  mem_io_arb_pick u_pick (.req0(m0_req), .req1(m1_req), .ptr(ptr_q), .grant(grant));
`else
  mem_io_arb_pick u_pick (.req0(m0_req), .req1(m1_req), .grant(grant));
`endif

  // Mux the winning requester's access and decode IO vs memory.
  always_comb begin
    sel_we     = grant ? m1_we    : m0_we;
    sel_addr   = grant ? m1_addr  : m0_addr;
    sel_wdata  = grant ? m1_wdata : m0_wdata;
    sel_io     = addr_is_io(sel_addr, IO_BASE);
    // IO reads return data during the strobe; writes answer with zero.
    issue_data = (io_q && !we_q) ? {16'h0000, io_rdata} : 32'h0;
  end

  assign busy      = (state_q != ST_IDLE);
  assign fsm_state = state_q;

  // Transaction FSM with registered bus strobes and responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      io_q      <= 1'b0;
`ifdef MEM_IO_ARB_RR_EN
      ptr_q     <= 1'b0;
`endif
      m0_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_ack    <= 1'b0;
      m1_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            win_q <= grant;
            we_q  <= sel_we;
            io_q  <= sel_io;
`ifdef MEM_IO_ARB_RR_EN
            ptr_q <= ~grant;
`endif
            if (sel_io) begin
              io_rd    <= !sel_we;
              io_wr    <= sel_we;
              io_addr  <= sel_addr;
              io_wdata <= sel_we ? sel_wdata : 32'h0;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= sel_addr[MEM_AW+1:2];
              mem_wdata <= sel_we ? sel_wdata : 32'h0;
            end
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          io_rd     <= 1'b0;
          io_wr     <= 1'b0;
          io_addr   <= '0;
          io_wdata  <= '0;
          if (!io_q && !we_q) begin
            state_q <= ST_WAIT;
          end else begin
            m0_ack   <= !win_q;
            m1_ack   <= win_q;
            m0_rdata <= win_q ? 32'h0 : issue_data;
            m1_rdata <= win_q ? issue_data : 32'h0;
            state_q  <= ST_RESP;
          end
        end
        ST_WAIT: begin
          m0_ack   <= !win_q;
          m1_ack   <= win_q;
          m0_rdata <= win_q ? 32'h0 : mem_rdata;
          m1_rdata <= win_q ? mem_rdata : 32'h0;
          state_q  <= ST_RESP;
        end
        default: begin
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          m0_rdata <= '0;
          m1_rdata <= '0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bus_arbiter.sv
// Directed bench for mem_io_bus_arbiter: a vector table of single
// transactions plus hand-written reset, contention and dropped-req sequences.
module tb_mem_io_bus_arbiter;
  import mem_io_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        io_rd, io_wr;
  logic [31:0] io_addr, io_wdata;
  logic [15:0] io_rdata;
  logic        busy;
  state_t      fsm_state;

  int checks   = 0;
  int failures = 0;

  mem_io_bus_arbiter #(.MEM_AW(14), .IO_BASE(32'hFFFF_FC00)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .busy(busy), .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        m;        // 0 = M0, 1 = M1
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] io_data;
    logic [31:0] mem_data;
    int          ack_cyc;
    logic [31:0] rdata;
    logic        is_io;
    logic [13:0] maddr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    mem_rdata = 0; io_rdata = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_acks"}, {30'b0, m0_ack, m1_ack}, 32'h0);
    chk({tag, "_strobes"}, {29'b0, mem_en, io_rd, io_wr}, 32'h0);
    chk({tag, "_bus"}, mem_addr | mem_wdata | io_addr | io_wdata | m0_rdata | m1_rdata, 32'h0);
  endtask

  // Drive one vector from a negedge, observe every cycle until the ack.
  task automatic run_vec(input vec_t v);
    int ack_cyc = 0, mem_cnt = 0, rd_cnt = 0, wr_cnt = 0, other_ack = 0;
    logic [31:0] rdata = 0, maddr = 0, mwd = 0, ioa = 0, iowd = 0;
    logic mwe = 0;
    mem_rdata = v.mem_data;
    io_rdata  = v.io_data;
    if (v.m) begin m1_req = 1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; end
    else     begin m0_req = 1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; end
    for (int c = 1; c <= 8 && ack_cyc == 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (mem_en) begin mem_cnt++; maddr = {18'b0, mem_addr}; mwe = mem_we; mwd = mem_wdata; end
      if (io_rd) begin rd_cnt++; ioa = io_addr; end
      if (io_wr) begin wr_cnt++; ioa = io_addr; iowd = io_wdata; end
      if (v.m ? m0_ack : m1_ack) other_ack++;
      if (v.m ? m1_ack : m0_ack) begin
        ack_cyc = c;
        rdata = v.m ? m1_rdata : m0_rdata;
        idle_inputs();
      end
    end
    chk({v.name, "_ack_cycle"}, ack_cyc, v.ack_cyc);
    chk({v.name, "_rdata"}, rdata, v.rdata);
    chk({v.name, "_loser_ack"}, other_ack, 0);
    if (v.is_io) begin
      chk({v.name, "_mem_en_cnt"}, mem_cnt, 0);
      chk({v.name, "_io_rd_cnt"}, rd_cnt, v.we ? 0 : 1);
      chk({v.name, "_io_wr_cnt"}, wr_cnt, v.we ? 1 : 0);
      chk({v.name, "_io_addr"}, ioa, v.addr);
      chk({v.name, "_io_wdata"}, iowd, v.we ? v.wdata : 32'h0);
    end else begin
      chk({v.name, "_mem_en_cnt"}, mem_cnt, 1);
      chk({v.name, "_io_cnt"}, rd_cnt + wr_cnt, 0);
      chk({v.name, "_mem_addr"}, maddr, {18'b0, v.maddr});
      chk({v.name, "_mem_we"}, {31'b0, mwe}, {31'b0, v.we});
      chk({v.name, "_mem_wdata"}, mwd, v.we ? v.wdata : 32'h0);
    end
    @(posedge clk); @(negedge clk);
    chk({v.name, "_busy_after"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    int acks, m1_acks, tmo, nack;
    logic exp_m;
    idle_inputs();

    //                name         m  we  addr          wdata         io      mem           cyc rdata        io  maddr
    vecs[0] = '{"m0_mem_rd",   0, 0, 32'h0000_0010, 32'h0,        16'h0,  32'h1122_3344, 3, 32'h1122_3344, 0, 14'd4};
    vecs[1] = '{"m1_mem_wr",   1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 16'h0, 32'h9999_9999, 2, 32'h0,        0, 14'd16};
    vecs[2] = '{"m0_io_rd",    0, 0, 32'hFFFF_FC70, 32'h0,        16'hA5A5, 32'h0,       2, 32'h0000_A5A5, 1, 14'd0};
    vecs[3] = '{"m0_io_wr",    0, 1, 32'hFFFF_FC80, 32'h0000_1234, 16'hFFFF, 32'h0,      2, 32'h0,        1, 14'd0};
    vecs[4] = '{"m1_mem_wrap", 1, 0, 32'h0001_000B, 32'h0,        16'h0,  32'hCAFE_F00D, 3, 32'hCAFE_F00D, 0, 14'd2};
    vecs[5] = '{"m1_io_rd",    1, 0, 32'hFFFF_FC60, 32'h0,        16'h8001, 32'h0,       2, 32'h0000_8001, 1, 14'd0};
    vecs[6] = '{"m0_mem_top",  0, 1, 32'h0000_FFFC, 32'h5A5A_5A5A, 16'h0, 32'h0,         2, 32'h0,        0, 14'h3FFF};

    // Reset block
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // Reset while a memory read sits in WAIT
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); @(negedge clk);
    chk("rst_pre_issue_state", {30'b0, fsm_state}, {30'b0, ST_ISSUE});
    @(posedge clk); @(negedge clk);
    chk("rst_pre_wait_state", {30'b0, fsm_state}, {30'b0, ST_WAIT});
    rst_n = 0;
    idle_inputs();
    #1;
    check_all_zero("rst_mid_wait");
    @(negedge clk);
    rst_n = 1;
    nack = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (m0_ack || m1_ack) nack++;
    end
    chk("rst_no_stale_ack", nack, 0);

    // Table of single transactions
    foreach (vecs[i]) run_vec(vecs[i]);

    // Both requesting for four transactions (fresh reset: pointer at M0)
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'hA0;
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'hB0;
    acks = 0; m1_acks = 0; tmo = 0;
    while (acks < 4 && tmo < 40) begin
      @(posedge clk); @(negedge clk);
      tmo++;
      if (m0_ack || m1_ack) begin
`ifdef MEM_IO_ARB_RR_EN
        exp_m = acks[0];
`else
        exp_m = 1'b0;
`endif
        chk($sformatf("contend_winner_%0d", acks), {31'b0, m1_ack}, {31'b0, exp_m});
        chk($sformatf("contend_one_ack_%0d", acks), {31'b0, m0_ack & m1_ack}, 32'h0);
        if (m1_ack) m1_acks++;
        acks++;
        if (acks == 4) idle_inputs();
      end
    end
    chk("contend_ack_count", acks, 4);
`ifdef MEM_IO_ARB_RR_EN
    chk("contend_m1_acks", m1_acks, 2);
`else
    chk("contend_m1_acks", m1_acks, 0);
`endif
    @(posedge clk); @(negedge clk);

    // M0 drops req while the read is in ISSUE
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0020; mem_rdata = 32'h0000_0077;
    @(posedge clk); @(negedge clk);
    chk("drop_issue_state", {30'b0, fsm_state}, {30'b0, ST_ISSUE});
    m0_req = 0;
    nack = 0; tmo = 0;
    for (int c = 2; c <= 7; c++) begin
      @(posedge clk); @(negedge clk);
      if (m0_ack) begin
        nack++;
        if (tmo == 0) tmo = c;
        chk("drop_rdata", m0_rdata, 32'h0000_0077);
      end
    end
    chk("drop_ack_count", nack, 1);
    chk("drop_ack_cycle", tmo, 3);
    chk("drop_busy_after", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
